// File: rtl/macro_reduction_gather_if.sv
// Handshake bundle between the gather stage and its sources/consumer.
// Sources drive in_*; the consumer drives out_ready; the gather stage drives the rest.
interface macro_reduction_gather_if #(
  parameter int INPUT_WIDTH = 1,
  parameter int INPUT_COUNT = 1
);
  logic [INPUT_COUNT-1:0]             in_valid;
  logic [INPUT_COUNT-1:0]             in_ready;
  logic [INPUT_WIDTH*INPUT_COUNT-1:0] in_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [INPUT_WIDTH*INPUT_COUNT-1:0] out_data;
  logic [INPUT_WIDTH-1:0]             out_q;
  logic [INPUT_COUNT-1:0]             arrived;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_q, arrived
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_q, arrived
  );
endinterface

// File: rtl/macro_reduction_gather.sv
// Gathers one vector per source, then presents the packed vector plus a
// registered per-bit NAND across all sources through one valid/ready port.
module macro_reduction_gather #(
  parameter int INPUT_WIDTH = 1,
  parameter int INPUT_COUNT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  macro_reduction_gather_if.slave bus
);

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t                 state_q, state_d;
  logic [INPUT_COUNT-1:0] arrived_q, arrived_d;
  logic [INPUT_WIDTH-1:0] out_q_q, out_q_d;
  logic [INPUT_WIDTH-1:0] slot_q [INPUT_COUNT];
  logic [INPUT_WIDTH-1:0] slot_d [INPUT_COUNT];
  logic [INPUT_COUNT-1:0] capture;
  logic [INPUT_WIDTH-1:0] and_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      arrived_q <= '0;
      out_q_q   <= '0;
      for (int i = 0; i < INPUT_COUNT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      out_q_q   <= out_q_d;
      for (int i = 0; i < INPUT_COUNT; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    out_q_d   = out_q_q;
    slot_d    = slot_q;
    and_acc   = '1;
    capture   = (state_q == COLLECT) ? (bus.in_valid & ~arrived_q) : '0;

    // The NAND must see data captured this very cycle, so reduce over slot_d.
    for (int i = 0; i < INPUT_COUNT; i++) begin
      if (capture[i]) begin
        slot_d[i] = bus.in_data[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
      and_acc = and_acc & slot_d[i];
    end

    case (state_q)
      COLLECT: begin
        arrived_d = arrived_q | capture;
        if (&arrived_d) begin
          state_d = OUTPUT;
          out_q_d = ~and_acc;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          state_d   = COLLECT;
          arrived_d = '0;
          out_q_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Abort discards this cycle's captures and any handshake.
    if (flush) begin
      slot_d    = slot_q;
      state_d   = COLLECT;
      arrived_d = '0;
      out_q_d   = '0;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT) ? ~arrived_q : '0;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_q     = out_q_q;
  assign bus.arrived   = arrived_q;

  for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_pack
    assign bus.out_data[gi*INPUT_WIDTH +: INPUT_WIDTH] = slot_q[gi];
  end

endmodule

// File: tb/tb_macro_reduction_gather.sv
// Directed, table-driven check of the gather stage with 3 sources of 4 bits.
module tb_macro_reduction_gather;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  macro_reduction_gather_if #(.INPUT_WIDTH(4), .INPUT_COUNT(3)) bus ();

  macro_reduction_gather #(.INPUT_WIDTH(4), .INPUT_COUNT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  vld;
    logic [11:0] din;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [2:0]  eir;
    logic [2:0]  earr;
    logic        chk_od;
    logic [11:0] eod;
    logic [3:0]  eoq;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic [2:0] vld, input logic [11:0] din, input logic ordy,
                     input logic fl, input logic ev, input logic [2:0] eir,
                     input logic [2:0] earr, input logic chk_od, input logic [11:0] eod,
                     input logic [3:0] eoq);
    vec_t v;
    v.vld = vld; v.din = din; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.eir = eir; v.earr = earr; v.chk_od = chk_od; v.eod = eod; v.eoq = eoq;
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0h want %0h", idx, nm, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic [2:0] eir,
                               input logic [2:0] earr, input logic chk_od,
                               input logic [11:0] eod, input logic [3:0] eoq);
    chk(idx, "out_valid", 32'(bus.out_valid), 32'(ev));
    chk(idx, "in_ready",  32'(bus.in_ready),  32'(eir));
    chk(idx, "arrived",   32'(bus.arrived),   32'(earr));
    chk(idx, "out_q",     32'(bus.out_q),     32'(eoq));
    if (chk_od) chk(idx, "out_data", 32'(bus.out_data), 32'(eod));
    $display("step %0d: out_valid=%0b in_ready=%03b arrived=%03b out_data=%03h out_q=%01h",
             idx, bus.out_valid, bus.in_ready, bus.arrived, bus.out_data, bus.out_q);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs(-1, 1'b0, 3'b111, 3'b000, 1'b1, 12'h000, 4'h0);

    // All sources in one cycle, then handshake
    add(3'b111, 12'h7FF, 0, 0, 1, 3'b000, 3'b111, 1, 12'h7FF, 4'h8);
    add(3'b000, 12'h000, 1, 0, 0, 3'b111, 3'b000, 0, 12'h000, 4'h0);
    // Staggered arrival src1 t0, src0 t2, src2 t5
    add(3'b010, 12'h0A0, 0, 0, 0, 3'b101, 3'b010, 0, 12'h000, 4'h0);
    add(3'b000, 12'h000, 0, 0, 0, 3'b101, 3'b010, 0, 12'h000, 4'h0);
    add(3'b001, 12'h005, 0, 0, 0, 3'b100, 3'b011, 0, 12'h000, 4'h0);
    add(3'b000, 12'h000, 0, 0, 0, 3'b100, 3'b011, 0, 12'h000, 4'h0);
    add(3'b000, 12'h000, 0, 0, 0, 3'b100, 3'b011, 0, 12'h000, 4'h0);
    add(3'b100, 12'hF00, 0, 0, 1, 3'b000, 3'b111, 1, 12'hFA5, 4'hF);
    add(3'b000, 12'h000, 1, 0, 0, 3'b111, 3'b000, 0, 12'h000, 4'h0);
    // Duplicate strobe on src0: second value 4'hC must be ignored
    add(3'b001, 12'h003, 0, 0, 0, 3'b110, 3'b001, 0, 12'h000, 4'h0);
    add(3'b001, 12'h00C, 0, 0, 0, 3'b110, 3'b001, 0, 12'h000, 4'h0);
    add(3'b110, 12'hFFC, 0, 0, 1, 3'b000, 3'b111, 1, 12'hFF3, 4'hC);
    // Backpressure with new data offered on every source
    for (int k = 0; k < 5; k++)
      add(3'b111, 12'h123, 0, 0, 1, 3'b000, 3'b111, 1, 12'hFF3, 4'hC);
    add(3'b111, 12'h456, 1, 0, 0, 3'b111, 3'b000, 0, 12'h000, 4'h0);
    // Flush mid-collect with a same-cycle src1 capture
    add(3'b101, 12'h906, 0, 0, 0, 3'b010, 3'b101, 0, 12'h000, 4'h0);
    add(3'b010, 12'h050, 0, 1, 0, 3'b111, 3'b000, 0, 12'h000, 4'h0);
    add(3'b000, 12'h000, 0, 0, 0, 3'b111, 3'b000, 0, 12'h000, 4'h0);
    // Flush in OUTPUT together with out_ready
    add(3'b111, 12'h111, 0, 0, 1, 3'b000, 3'b111, 1, 12'h111, 4'hE);
    add(3'b000, 12'h000, 1, 1, 0, 3'b111, 3'b000, 0, 12'h000, 4'h0);
    // Normal round after the flush, left in OUTPUT for the reset check
    add(3'b111, 12'h0F0, 0, 0, 1, 3'b000, 3'b111, 1, 12'h0F0, 4'hF);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.in_valid  = vecs[i].vld;
      bus.in_data   = vecs[i].din;
      bus.out_ready = vecs[i].ordy;
      flush         = vecs[i].fl;
      @(posedge clk);
      #1;
      check_outputs(i, vecs[i].ev, vecs[i].eir, vecs[i].earr, vecs[i].chk_od,
                    vecs[i].eod, vecs[i].eoq);
    end

    // Reset while in OUTPUT clears everything including slot data
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs(100, 1'b0, 3'b111, 3'b000, 1'b1, 12'h000, 4'h0);

    // Reset round trip: a single-source capture must not complete a round
    bus.in_valid = 3'b100;
    bus.in_data  = 12'hA00;
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    check_outputs(101, 1'b0, 3'b011, 3'b100, 1'b1, 12'hA00, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/macro_reduction_gather.md
# macro_reduction_gather

Multi-source gather stage that sits directly upstream of the NAND/AND/OR reduction macros. It collects one INPUT_WIDTH-bit vector from each of INPUT_COUNT independent sources over any number of cycles, each source with its own valid/ready handshake. Once every source has delivered, it presents the packed vector together with a registered per-bit NAND reduction through a single valid/ready output port. The packed layout, source i at bits [i*INPUT_WIDTH +: INPUT_WIDTH], is exactly the d layout the reduction macros consume.

## Interface

- INPUT_WIDTH, 1, bits per source vector (≥1)
- INPUT_COUNT, 1, number of sources (≥1)

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort of the current gather round
- in_valid  input  INPUT_COUNT  per-source valid strobe
- in_ready  output  INPUT_COUNT  per-source ready; bit i high when slot i is empty and state is COLLECT
- in_data  input  INPUT_WIDTH*INPUT_COUNT  per-source data, source i at [i*INPUT_WIDTH +: INPUT_WIDTH]
- out_valid  output  1  gathered result available
- out_ready  input  1  consumer accepts result
- out_data  output  INPUT_WIDTH*INPUT_COUNT  packed gathered vectors, same layout as in_data
- out_q  output  INPUT_WIDTH  registered per-bit NAND across all sources: out_q[j] = ~&{slot[i][j] for all i}
- arrived  output  INPUT_COUNT  current slot-filled mask (status/debug)

## Operation

- State register: COLLECT, then OUTPUT.
- Storage: INPUT_COUNT slots of INPUT_WIDTH bits, the arrival mask, out_q register.
- COLLECT:
  - in_ready = ~arrived.
  - Source i is captured when in_valid[i] & in_ready[i]: slot i ← in_data[i], arrived[i] ← 1.
  - in_valid[i] while arrived[i]=1 is ignored. Slot contents and mask do not change.
  - Any number of sources may be captured in the same cycle.
  - When (arrived | captured-this-cycle) becomes all ones, the next state is OUTPUT.
  - On that same edge, out_q is loaded from the NAND of the final slot values, including data captured in that cycle.
- OUTPUT:
  - in_ready = 0 and out_valid = 1.
  - out_data and out_q hold stable until the handshake completes.
  - out_valid & out_ready clears arrived to 0, returns the state to COLLECT and clears out_q to 0.
  - Slot data is not cleared; out_data shows stale slots while in COLLECT and is only meaningful when out_valid=1.
- flush, in any state: arrived ← 0, state ← COLLECT, out_q ← 0. Captures and the output handshake in that cycle are discarded. flush has priority over every other event in the same cycle.
- reset has the same effect as flush and additionally clears all slots to 0.
- Reset values: out_valid 0, out_data 0, out_q 0, arrived 0, in_ready all ones on the first cycle after reset deasserts.
- INPUT_COUNT=1 degenerates to a one-entry buffer with out_q = ~in_data.

## Timing

- Capture to out_valid latency: 1 cycle. out_valid rises on the edge that captures the last missing source.
- Output to next round: after the out_valid&out_ready edge, in_ready returns high the next cycle.
- No capture is possible in the handshake cycle. Minimum round period is 2 cycles (all sources in cycle 0, handshake in cycle 1).
- No combinational path from in_valid to in_ready, or from out_ready to in_ready. in_ready depends only on registered state.
- out_valid, out_data, out_q and arrived are all registered outputs.
- out_valid must not drop without a handshake, except by flush or reset.

## Test plan

- Parameters INPUT_WIDTH=4, INPUT_COUNT=3. Drive 4'hF, 4'hF, 4'h7 from sources 0, 1, 2 in one cycle. Required: out_valid=1 next cycle, out_data=12'h7FF, out_q=4'h8, in_ready=3'b000.
- Staggered arrival: src1=4'hA at t0, src0=4'h5 at t2, src2=4'hF at t5. Required: arrived goes 3'b010 → 3'b011 → 3'b111; out_valid rises at t6; out_data=12'hFA5; out_q=4'hF.
- Duplicate strobe: src0=4'h3 accepted at t0, then src0=4'hC at t1. Required: in_ready[0]=0 at t1 and slot 0 still 4'h3 when the round completes.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid all ones and new data. Required: out_data and out_q stable, no capture. Then out_ready=1 for one cycle. Required: out_valid=0 and in_ready=3'b111 next cycle.
- Flush mid-collect with arrived=3'b101, plus a same-cycle capture of src1. Required: arrived=0, out_valid stays 0, and the src1 capture is lost. Separately, flush in OUTPUT with out_ready=1. Required: out_valid=0 and state COLLECT.
- Assert reset while in OUTPUT. Required: next cycle out_valid=0, out_data=0, out_q=0, arrived=0, in_ready=3'b111.
